commit_rrat: RTL and testbench
==============================

COMMIT_RRAT -- requirements
Module: commit_rrat

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush_out is held after a mispredicted commit; legal range 1-15.
REQ-002 SHALL have ports CLK (input, 1) and RESET (input, 1); one clock, and reset is synchronous and active-high.
REQ-003 SHALL have port STALL (input, 1): when high, no commit is accepted.
REQ-004 SHALL have port rob_commit_valid (input, 1): the ROB head is ready to retire.
REQ-005 SHALL have port rob_commit_regwr (input, 1): the retiring instruction owns a newly allocated physical register.
REQ-006 SHALL have port rob_commit_arch (input, 5): the architectural destination.
REQ-007 SHALL have port rob_commit_phys (input, 6): the physical register allocated at rename.
REQ-008 SHALL have port rob_commit_mispredict (input, 1): the retiring branch was mispredicted.
REQ-009 SHALL have port rob_commit_target (input, 32): the correct PC for a mispredicted branch.
REQ-010 SHALL have port commit_ready (output, 1): the commit handshake acknowledge.
REQ-011 SHALL have port rrat_map (output, 192): the packed retirement map; entry i sits at bits [6i+5:6i].
REQ-012 SHALL have ports rrat_free (output, 1) and rrat_free_reg (output, 6): a freed physical register returned to the rename freelist.
REQ-013 SHALL have ports flush_out (output, 1) and flush_pc (output, 32): the pipeline flush and the redirect PC.
REQ-014 SHALL have port commit_count (output, 32): the number of retired instructions.

Function
REQ-015 SHALL hold a 32-entry x 6-bit retirement map and a state register with the states IDLE and FLUSH.
REQ-016 SHALL drive commit_ready combinationally as (state==IDLE) & !STALL.
REQ-017 SHALL accept a commit on a rising CLK edge only when rob_commit_valid & commit_ready; otherwise there SHALL be no state, map or counter change.
REQ-018 On an accepted commit with regwr=1 and arch!=0:
  - map[arch] SHALL take rob_commit_phys;
  - on the next cycle, rrat_free SHALL be 1 and rrat_free_reg SHALL equal the prior map[arch].
REQ-019 On an accepted commit with regwr=1 and arch==0:
  - map[0] SHALL stay 0;
  - on the next cycle, rrat_free SHALL be 1 and rrat_free_reg SHALL equal rob_commit_phys, so the physical register does not leak.
REQ-020 On an accepted commit with regwr=0, rrat_free SHALL be 0 on the next cycle.
REQ-021 rrat_free SHALL be a one-cycle registered pulse per qualifying commit, and SHALL NEVER carry physical register 0.
REQ-022 Back-to-back commits to the same arch SHALL read the updated map: the second commit frees the first commit's phys.
REQ-023 commit_count SHALL increment by 1 per accepted commit and wrap modulo 2^32.
REQ-024 On an accepted commit with mispredict=1:
  - the map update and free SHALL occur as normal;
  - state SHALL go IDLE->FLUSH;
  - flush_pc SHALL take rob_commit_target;
  - flush_out SHALL be 1 starting the next cycle, for exactly FLUSH_CYCLES cycles;
  - state SHALL then return to IDLE.
REQ-025 In FLUSH, a down-counter SHALL load FLUSH_CYCLES-1 and decrement each cycle; FLUSH->IDLE SHALL happen when the counter is 0.
REQ-026 STALL SHALL NOT extend or shorten FLUSH.
REQ-027 flush_pc SHALL hold its value until the next mispredicted commit.
REQ-028 rrat_map SHALL reflect the registered map, with updates visible the cycle after the commit.

Reset
REQ-029 On RESET high at a rising CLK edge:
  - map[i] SHALL be i for i=0..31 (identity), so physical registers 32-63 are free;
  - state SHALL be IDLE;
  - rrat_free, rrat_free_reg, flush_out, flush_pc and commit_count SHALL be 0.
REQ-030 RESET SHALL take priority over every commit.
REQ-031 RESET asserted mid-FLUSH SHALL abort the flush, with flush_out 0 the following cycle.

Verification
REQ-032 Reset, then commit {regwr=1, arch=5, phys=40} -> next cycle rrat_free=1, rrat_free_reg=5, map[5]=40, commit_count=1.
REQ-033 Consecutive commits arch=7/phys=33, then arch=7/phys=34 -> frees 7, then 33; map[7]=34.
REQ-034 Commit {regwr=1, arch=0, phys=50} -> rrat_free_reg=50; map[0]=0.
REQ-035 Commit mispredict=1, target=0x00400100, FLUSH_CYCLES=2 -> flush_out high 2 cycles, flush_pc=0x00400100, commit_ready low during FLUSH; a valid commit held high through FLUSH is accepted only after return to IDLE.
REQ-036 STALL=1 with rob_commit_valid=1 for 3 cycles -> commit_ready=0, no map/free/count change; acceptance occurs on the first cycle after STALL drops.
REQ-037 RESET pulsed during the second FLUSH cycle -> flush_out 0 next cycle, identity map restored, commit_count=0.

Source files
------------

// File: rtl/commit_rrat.sv
// commit_rrat -- retirement register alias table with commit-side flush.
//
// Holds the architectural-to-physical map as seen by retired instructions.
// Each accepted commit may update one map entry and hand the displaced
// physical register back to the rename freelist. A mispredicted branch
// retiring here raises a flush for FLUSH_CYCLES cycles with the redirect PC,
// and no further commits are accepted until the flush has drained.
//
// Ports
//   CLK                   : clock, all state changes on its rising edge
//   RESET                 : synchronous active-high reset
//   STALL                 : blocks commit acceptance while high
//   rob_commit_valid      : ROB head is ready to retire
//   rob_commit_regwr      : retiring instruction owns a new physical register
//   rob_commit_arch       : architectural destination register
//   rob_commit_phys       : physical register allocated at rename
//   rob_commit_mispredict : retiring branch was mispredicted
//   rob_commit_target     : correct PC for the mispredicted branch
//   commit_ready          : commit handshake acknowledge
//   rrat_map              : packed map, entry i at bits [6i+5:6i]
//   rrat_free             : one-cycle pulse, a physical register is released
//   rrat_free_reg         : the released physical register
//   flush_out             : pipeline flush request
//   flush_pc              : redirect PC for the flush
//   commit_count          : retired instruction count, wraps at 2^32

module commit_rrat #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         STALL,
  input  logic         rob_commit_valid,
  input  logic         rob_commit_regwr,
  input  logic [4:0]   rob_commit_arch,
  input  logic [5:0]   rob_commit_phys,
  input  logic         rob_commit_mispredict,
  input  logic [31:0]  rob_commit_target,
  output logic         commit_ready,
  output logic [191:0] rrat_map,
  output logic         rrat_free,
  output logic [5:0]   rrat_free_reg,
  output logic         flush_out,
  output logic [31:0]  flush_pc,
  output logic [31:0]  commit_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [0:0] state;
  logic [3:0] flush_cnt;
  logic [5:0] map [32];

  logic       accept;
  logic       arch_zero;
  logic [5:0] old_phys;
  logic [5:0] freed_reg;

  assign commit_ready = (state == IDLE) & ~STALL;
  assign accept       = rob_commit_valid & commit_ready;
  assign arch_zero    = (rob_commit_arch == 5'd0);
  assign old_phys     = map[rob_commit_arch];

  // Architectural r0 never takes a mapping, so the register allocated for it
  // is returned directly instead of the (always zero) old mapping.
  assign freed_reg    = arch_zero ? rob_commit_phys : old_phys;

  genvar g;
  generate
    for (g = 0; g < 32; g++) begin : g_map_out
      assign rrat_map[6*g +: 6] = map[g];
    end
  endgenerate

  // Main sequential block. The flush countdown and commit acceptance are
  // mutually exclusive because commit_ready is low in FLUSH. Physical
  // register 0 is never reported as freed, since it is permanently bound
  // to architectural r0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        map[i] <= 6'(i);
      end
      state         <= IDLE;
      flush_cnt     <= 4'd0;
      rrat_free     <= 1'b0;
      rrat_free_reg <= 6'd0;
      flush_out     <= 1'b0;
      flush_pc      <= 32'd0;
      commit_count  <= 32'd0;
    end else begin
      rrat_free <= 1'b0;

      if (state == FLUSH) begin
        if (flush_cnt == 4'd0) begin
          state     <= IDLE;
          flush_out <= 1'b0;
        end else begin
          flush_cnt <= flush_cnt - 4'd1;
        end
      end

      if (accept) begin
        commit_count <= commit_count + 32'd1;

        if (rob_commit_regwr) begin
          if (!arch_zero) begin
            map[rob_commit_arch] <= rob_commit_phys;
          end
          rrat_free     <= (freed_reg != 6'd0);
          rrat_free_reg <= freed_reg;
        end

        if (rob_commit_mispredict) begin
          state     <= FLUSH;
          flush_cnt <= FLUSH_LOAD;
          flush_out <= 1'b1;
          flush_pc  <= rob_commit_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_rrat.sv
// tb_commit_rrat -- self-checking bench for commit_rrat.
//
// A reference model steps on every rising edge and pushes the expected
// post-edge outputs into a scoreboard queue; the entry is popped and compared
// just after the edge. Directed sequences on top check the key scenarios with
// fixed expected values.

module tb_commit_rrat;

  localparam int FC = 2;

  logic         CLK;
  logic         RESET;
  logic         STALL;
  logic         rob_commit_valid;
  logic         rob_commit_regwr;
  logic [4:0]   rob_commit_arch;
  logic [5:0]   rob_commit_phys;
  logic         rob_commit_mispredict;
  logic [31:0]  rob_commit_target;
  logic         commit_ready;
  logic [191:0] rrat_map;
  logic         rrat_free;
  logic [5:0]   rrat_free_reg;
  logic         flush_out;
  logic [31:0]  flush_pc;
  logic [31:0]  commit_count;

  int checks;
  int failures;

  commit_rrat #(.FLUSH_CYCLES(FC)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .STALL                 (STALL),
    .rob_commit_valid      (rob_commit_valid),
    .rob_commit_regwr      (rob_commit_regwr),
    .rob_commit_arch       (rob_commit_arch),
    .rob_commit_phys       (rob_commit_phys),
    .rob_commit_mispredict (rob_commit_mispredict),
    .rob_commit_target     (rob_commit_target),
    .commit_ready          (commit_ready),
    .rrat_map              (rrat_map),
    .rrat_free             (rrat_free),
    .rrat_free_reg         (rrat_free_reg),
    .flush_out             (flush_out),
    .flush_pc              (flush_pc),
    .commit_count          (commit_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of commit inputs; returns at the following negedge, by
  // which time the outputs of the sampling edge are settled.
  task automatic applyStimulus(input logic v, input logic regwr,
                               input logic [4:0] arch, input logic [5:0] phys,
                               input logic mis, input logic [31:0] tgt,
                               input logic stall);
    rob_commit_valid      = v;
    rob_commit_regwr      = regwr;
    rob_commit_arch       = arch;
    rob_commit_phys       = phys;
    rob_commit_mispredict = mis;
    rob_commit_target     = tgt;
    STALL                 = stall;
    @(negedge CLK);
  endtask

  typedef struct packed {
    logic         free;
    logic [5:0]   free_reg;
    logic         flush;
    logic [31:0]  pc;
    logic [31:0]  count;
    logic [191:0] map;
  } exp_t;

  exp_t        sb_q[$];
  logic [5:0]  mdl_map [32];
  int          mdl_left;
  logic [31:0] mdl_count;
  logic [31:0] mdl_pc;
  logic        mdl_free;
  logic [5:0]  mdl_free_reg;
  logic [191:0] identity_map;

  // Reference model and scoreboard: predict at the edge, compare 1 ns later.
  initial begin
    exp_t e;
    exp_t got;
    logic acc;
    logic [5:0] fr;
    forever begin
      @(posedge CLK);
      if (RESET) begin
        for (int i = 0; i < 32; i++) mdl_map[i] = 6'(i);
        mdl_left  = 0;
        mdl_count = 0;
        mdl_pc    = 0;
        mdl_free  = 0;
      end else begin
        acc      = rob_commit_valid && !STALL && (mdl_left == 0);
        mdl_free = 0;
        if (mdl_left != 0) mdl_left--;
        if (acc) begin
          mdl_count++;
          if (rob_commit_regwr) begin
            fr = (rob_commit_arch == 0) ? rob_commit_phys : mdl_map[rob_commit_arch];
            mdl_free     = (fr != 0);
            mdl_free_reg = fr;
            if (rob_commit_arch != 0) mdl_map[rob_commit_arch] = rob_commit_phys;
          end
          if (rob_commit_mispredict) begin
            mdl_left = FC;
            mdl_pc   = rob_commit_target;
          end
        end
      end
      e.free     = mdl_free;
      e.free_reg = mdl_free_reg;
      e.flush    = (mdl_left != 0);
      e.pc       = mdl_pc;
      e.count    = mdl_count;
      for (int i = 0; i < 32; i++) e.map[6*i +: 6] = mdl_map[i];
      sb_q.push_back(e);
      #1;
      got = sb_q.pop_front();
      checkOutput("sb_free", 192'(rrat_free), 192'(got.free));
      if (got.free) checkOutput("sb_free_reg", 192'(rrat_free_reg), 192'(got.free_reg));
      checkOutput("sb_flush_out", 192'(flush_out), 192'(got.flush));
      checkOutput("sb_flush_pc", 192'(flush_pc), 192'(got.pc));
      checkOutput("sb_count", 192'(commit_count), 192'(got.count));
      checkOutput("sb_map", rrat_map, got.map);
      checkOutput("sb_ready", 192'(commit_ready), 192'((mdl_left == 0) && !STALL));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) identity_map[6*i +: 6] = 6'(i);

    RESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;

    checkOutput("rst_map", rrat_map, identity_map);
    checkOutput("rst_count", 192'(commit_count), 192'd0);
    checkOutput("rst_free", 192'(rrat_free), 192'd0);
    checkOutput("rst_flush", 192'(flush_out), 192'd0);
    checkOutput("rst_pc", 192'(flush_pc), 192'd0);
    checkOutput("rst_ready", 192'(commit_ready), 192'd1);

    // First commit frees the identity mapping of r5.
    applyStimulus(1, 1, 5'd5, 6'd40, 0, 0, 0);
    checkOutput("c1_free", 192'(rrat_free), 192'd1);
    checkOutput("c1_free_reg", 192'(rrat_free_reg), 192'd5);
    checkOutput("c1_map5", 192'(rrat_map[30 +: 6]), 192'd40);
    checkOutput("c1_count", 192'(commit_count), 192'd1);

    // Back-to-back to r7: the second sees the first's mapping.
    applyStimulus(1, 1, 5'd7, 6'd33, 0, 0, 0);
    checkOutput("b2b1_free_reg", 192'(rrat_free_reg), 192'd7);
    applyStimulus(1, 1, 5'd7, 6'd34, 0, 0, 0);
    checkOutput("b2b2_free", 192'(rrat_free), 192'd1);
    checkOutput("b2b2_free_reg", 192'(rrat_free_reg), 192'd33);
    checkOutput("b2b2_map7", 192'(rrat_map[42 +: 6]), 192'd34);

    // r0 destination: map untouched, allocated register returned.
    applyStimulus(1, 1, 5'd0, 6'd50, 0, 0, 0);
    checkOutput("r0_free_reg", 192'(rrat_free_reg), 192'd50);
    checkOutput("r0_map0", 192'(rrat_map[0 +: 6]), 192'd0);

    // No register write: no free pulse.
    applyStimulus(1, 0, 5'd9, 6'd55, 0, 0, 0);
    checkOutput("nowr_free", 192'(rrat_free), 192'd0);
    checkOutput("nowr_count", 192'(commit_count), 192'd5);

    // Mispredict, then a valid commit held through the flush.
    applyStimulus(1, 0, 5'd0, 6'd0, 1, 32'h0040_0100, 0);
    checkOutput("mp_flush1", 192'(flush_out), 192'd1);
    checkOutput("mp_pc", 192'(flush_pc), 192'h0040_0100);
    checkOutput("mp_ready1", 192'(commit_ready), 192'd0);
    applyStimulus(1, 1, 5'd3, 6'd45, 0, 0, 0);
    checkOutput("mp_flush2", 192'(flush_out), 192'd1);
    checkOutput("mp_ready2", 192'(commit_ready), 192'd0);
    checkOutput("mp_hold_count", 192'(commit_count), 192'd6);
    applyStimulus(1, 1, 5'd3, 6'd45, 0, 0, 0);
    checkOutput("mp_flush_end", 192'(flush_out), 192'd0);
    checkOutput("mp_hold_count2", 192'(commit_count), 192'd6);
    applyStimulus(1, 1, 5'd3, 6'd45, 0, 0, 0);
    checkOutput("mp_after_count", 192'(commit_count), 192'd7);
    checkOutput("mp_after_free_reg", 192'(rrat_free_reg), 192'd3);
    checkOutput("mp_pc_hold", 192'(flush_pc), 192'h0040_0100);

    // Stall with valid held for three cycles.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 5'd9, 6'd60, 0, 0, 1);
      checkOutput("stall_ready", 192'(commit_ready), 192'd0);
      checkOutput("stall_free", 192'(rrat_free), 192'd0);
      checkOutput("stall_count", 192'(commit_count), 192'd7);
    end
    applyStimulus(1, 1, 5'd9, 6'd60, 0, 0, 0);
    checkOutput("unstall_count", 192'(commit_count), 192'd8);
    checkOutput("unstall_free_reg", 192'(rrat_free_reg), 192'd9);
    checkOutput("unstall_map9", 192'(rrat_map[54 +: 6]), 192'd60);

    // Reset during the second flush cycle.
    applyStimulus(1, 0, 5'd0, 6'd0, 1, 32'h1234_5678, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rf2_flush_before", 192'(flush_out), 192'd1);
    RESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;
    checkOutput("rf2_flush", 192'(flush_out), 192'd0);
    checkOutput("rf2_map", rrat_map, identity_map);
    checkOutput("rf2_count", 192'(commit_count), 192'd0);

    // Reset during the first flush cycle must cut the flush short.
    applyStimulus(1, 0, 5'd0, 6'd0, 1, 32'hCAFE_0000, 0);
    RESET = 1'b1;
    applyStimulus(1, 1, 5'd4, 6'd44, 0, 0, 0);
    RESET = 1'b0;
    checkOutput("rf1_flush", 192'(flush_out), 192'd0);
    checkOutput("rf1_pc", 192'(flush_pc), 192'd0);
    checkOutput("rf1_ready", 192'(commit_ready), 192'd1);

    // Random traffic, checked by the scoreboard each cycle.
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 99) == 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 6'($urandom_range(1, 63)),
                    1'($urandom_range(0, 15) == 0), $urandom(),
                    1'($urandom_range(0, 4) == 0));
    end
    RESET = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
